uart_rx_os: RTL and testbench

- UART receiver that pairs with the team's existing 16x-oversampled UART transmitter; shares the same baud-tick generator (`s_tick`).
- Synchronises the serial input, validates the start bit, samples each data bit at mid-bit (LSB first), checks the stop bit, and delivers the byte through a one-entry holding register with a valid/ready handshake.
- Reports framing and overrun errors.

---
 rtl/uart_rx_os.sv | 139 +++++++++++++
 tb/tb_uart_rx_os.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// 16x-oversampled UART receiver with a one-entry valid/ready holding register.
// Reports framing errors (bad stop sample) and sticky overrun errors.
module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  input  logic       rx_ready,
  input  logic       clr_err,
  output logic [7:0] dout,
  output logic       rx_valid,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       overrun_err,
  output logic [1:0] fsm_state
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;

  typedef enum logic [1:0] {st_idle, st_start, st_data, st_stop} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [2:0]      n, n_next;
  logic [DBIT-1:0] shift, shift_next;
  logic            stop_sample, stop_next;
  logic            rx_meta, rx_s;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= st_idle;
      s           <= '0;
      n           <= '0;
      shift       <= '0;
      stop_sample <= 1'b0;
    end else begin
      state       <= state_next;
      s           <= s_next;
      n           <= n_next;
      shift       <= shift_next;
      stop_sample <= stop_next;
    end
  end

  always_comb begin
    state_next   = state;
    s_next       = s;
    n_next       = n;
    shift_next   = shift;
    stop_next    = stop_sample;
    rx_done_tick = 1'b0;
    case (state)
      st_idle: begin
        if (!rx_s) begin
          state_next = st_start;
          s_next     = '0;
        end
      end
      st_start: begin
        if (s_tick) begin
          if (s == SW'(7)) begin
            s_next = '0;
            if (!rx_s) begin
              state_next = st_data;
              n_next     = '0;
            end else begin
              state_next = st_idle;
            end
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      st_data: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_next     = '0;
            shift_next = DBIT'({rx_s, shift} >> 1);
            if (n == 3'(DBIT - 1)) state_next = st_stop;
            else                   n_next     = n + 3'd1;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      st_stop: begin
        // With SB_TICK=8 capture and completion share a tick, so frame_err uses stop_next.
        if (s_tick) begin
          if (s == SW'(7)) stop_next = rx_s;
          if (s == SW'(SB_TICK - 1)) begin
            state_next   = st_idle;
            s_next       = '0;
            rx_done_tick = 1'b1;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      default: state_next = st_idle;
    endcase
  end

  // Handshake: a byte is transferred on any rising edge with rx_valid && rx_ready;
  // dout is stable while rx_valid=1 unless a new frame overwrites it (overrun).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout        <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (rx_done_tick) begin
        dout      <= 8'(shift);
        frame_err <= ~stop_next;
        rx_valid  <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (rx_done_tick && rx_valid && !rx_ready) overrun_err <= 1'b1;
      else if (clr_err)                           overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: table-driven frames plus hand-written corner sequences,
// with a scoreboard queue of expected {frame_err, dout} checked on each rx_done_tick.
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] dout;
  logic       rx_valid, rx_done_tick, frame_err, overrun_err;
  logic [1:0] fsm_state;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int done_cnt = 0;
  int tick_cnt = 0;
  logic pending = 1'b0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;
  vec_t tbl[4];

  uart_rx_os #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx), .rx_ready(rx_ready),
    .clr_err(clr_err), .dout(dout), .rx_valid(rx_valid), .rx_done_tick(rx_done_tick),
    .frame_err(frame_err), .overrun_err(overrun_err), .fsm_state(fsm_state)
  );

  // clock / reset / tick block
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_cnt = (tick_cnt == 15) ? 0 : tick_cnt + 1;
      s_tick   = (tick_cnt == 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver tasks (main thread runs 2ns after each rising edge)
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic align_tick();
    while (tick_cnt != 14) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    align_tick();
    rx = 1'b0;
    wait_clks(256);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(256);
    end
    rx = stop;
    wait_clks(256);
    rx = 1'b1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe);
    exp_q.push_back({fe, d});
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
  endtask

  // scoreboard: compare registered outputs one cycle after each rx_done_tick
  always @(negedge clk) begin
    logic [8:0] e;
    if (pending) begin
      pending = 1'b0;
      check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_dout", 32'(dout), 32'(e[7:0]));
        check("sb_frame_err", 32'(frame_err), 32'(e[8]));
        check("sb_rx_valid", 32'(rx_valid), 32'd1);
      end
    end
    if (rx_done_tick) begin
      pending = 1'b1;
      done_cnt++;
    end
  end

  initial begin
    int base;
    int seen;
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    tbl[2] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
    tbl[3] = '{8'h81, 1'b1, 8'h81, 1'b0};

    wait_clks(3);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun_err), 32'h0);
    check("rst_done", 32'(rx_done_tick), 32'h0);
    check("rst_state", 32'(fsm_state), 32'h0);
    reset = 1'b1;
    wait_clks(2);

    for (int i = 0; i < 4; i++) begin
      push_exp(tbl[i].exp_dout, tbl[i].exp_ferr);
      send_frame(tbl[i].data, tbl[i].stop);
      wait_clks(300);
      check("tbl_rx_valid", 32'(rx_valid), 32'd1);
      check("tbl_dout", 32'(dout), 32'(tbl[i].exp_dout));
      check("tbl_frame_err", 32'(frame_err), 32'(tbl[i].exp_ferr));
      pulse_ready();
      check("tbl_consumed", 32'(rx_valid), 32'd0);
      check("tbl_dout_hold", 32'(dout), 32'(tbl[i].exp_dout));
    end

    // start-bit glitch: 4 s_ticks low
    base = done_cnt;
    align_tick();
    rx = 1'b0;
    wait_clks(32);
    check("glitch_in_start", 32'(fsm_state), 32'd1);
    wait_clks(32);
    rx = 1'b1;
    wait_clks(512);
    check("glitch_no_done", 32'(done_cnt), 32'(base));
    check("glitch_rx_valid", 32'(rx_valid), 32'd0);
    check("glitch_idle", 32'(fsm_state), 32'd0);

    // overrun and clear
    push_exp(8'h11, 1'b0);
    send_frame(8'h11, 1'b1);
    wait_clks(100);
    check("ovr_first_clean", 32'(overrun_err), 32'd0);
    push_exp(8'h22, 1'b0);
    send_frame(8'h22, 1'b1);
    wait_clks(300);
    check("ovr_dout", 32'(dout), 32'h22);
    check("ovr_rx_valid", 32'(rx_valid), 32'd1);
    check("ovr_flag", 32'(overrun_err), 32'd1);
    clr_err = 1'b1;
    wait_clks(1);
    clr_err = 1'b0;
    check("clr_overrun", 32'(overrun_err), 32'd0);
    check("clr_dout_kept", 32'(dout), 32'h22);

    // reset during data bit 3 of 0xFF
    base = done_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_clks(16 + 1024 + 128);
        reset = 1'b0;
        wait_clks(1);
        check("mid_rst_dout", 32'(dout), 32'h0);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_ferr", 32'(frame_err), 32'd0);
        check("mid_rst_ovr", 32'(overrun_err), 32'd0);
        check("mid_rst_state", 32'(fsm_state), 32'd0);
        wait_clks(2);
        reset = 1'b1;
      end
    join
    wait_clks(300);
    check("mid_rst_no_done", 32'(done_cnt), 32'(base));
    push_exp(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1);
    wait_clks(300);
    check("after_rst_dout", 32'(dout), 32'h5A);
    pulse_ready();

    // back-to-back frames; second completion coincides with the handshake
    base = done_cnt;
    push_exp(8'h00, 1'b0);
    push_exp(8'hFF, 1'b0);
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        seen = 0;
        for (int cyc = 0; cyc < 6000 && seen < 2; cyc++) begin
          @(negedge clk);
          if (rx_done_tick) begin
            seen++;
            if (seen == 2) rx_ready = 1'b1;
          end
        end
        check("b2b_done_seen", 32'(seen), 32'd2);
      end
    join
    wait_clks(300);
    rx_ready = 1'b0;
    check("b2b_done_cnt", 32'(done_cnt), 32'(base + 2));
    check("b2b_dout", 32'(dout), 32'hFF);
    check("b2b_overrun", 32'(overrun_err), 32'd0);
    check("b2b_consumed", 32'(rx_valid), 32'd0);

    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
